// File: rtl/network_injector_pkg.sv
// Network defines shared by the injector: tile addressing, router port encoding and flit format.
package network_injector_pkg;

  localparam int VC_PER_PORT   = 2;
  localparam int VC_W          = $clog2(VC_PER_PORT);
  localparam int PAYLOAD_W     = 16;
  localparam int COORD_W       = 4;
  // Default packet size, shared with the ejection side.
  localparam int DEF_MAX_FLITS = 4;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } tile_address_t;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2,
    HT     = 2'd3
  } flit_type_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    EAST  = 3'd1,
    NORTH = 3'd2,
    WEST  = 3'd3,
    SOUTH = 3'd4
  } port_t;

  typedef struct packed {
    flit_type_t          flit_type;
    port_t               next_hop_port;
    logic [VC_W-1:0]     vc_id;
    tile_address_t       destination;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } inj_state_t;

endpackage

// File: rtl/network_injector_if.sv
// Packet offer side plus router local-port side of the injector, bundled as one interface.
interface network_injector_if
  import network_injector_pkg::*;
#(
  parameter int MAX_FLITS = DEF_MAX_FLITS
) ();

  logic                                  pkt_valid;
  logic                                  pkt_ready;
  logic [VC_W-1:0]                       pkt_vc;
  tile_address_t                         pkt_dest;
  logic [$clog2(MAX_FLITS+1)-1:0]        pkt_len;
  logic [MAX_FLITS-1:0][PAYLOAD_W-1:0]   pkt_data;
  logic [VC_PER_PORT-1:0]                on_off_in;
  logic                                  wr_en_out;
  flit_t                                 flit_out;

  // The injector is the master: it drives flits towards the router.
  modport master (
    input  pkt_valid, pkt_vc, pkt_dest, pkt_len, pkt_data, on_off_in,
    output pkt_ready, wr_en_out, flit_out
  );

  modport slave (
    output pkt_valid, pkt_vc, pkt_dest, pkt_len, pkt_data, on_off_in,
    input  pkt_ready, wr_en_out, flit_out
  );

endinterface

// File: rtl/network_injector_route_calc.sv
// Look-ahead XY dimension-order route for the header flit; X is resolved before Y.
module injection_route_calc
  import network_injector_pkg::*;
#(
  parameter int MY_X_ADDR = 0,
  parameter int MY_Y_ADDR = 0
) (
  input  tile_address_t dest,
  output port_t         port
);

  localparam logic [COORD_W-1:0] myX = COORD_W'(MY_X_ADDR);
  localparam logic [COORD_W-1:0] myY = COORD_W'(MY_Y_ADDR);

  always_comb begin
    port = LOCAL;
    if (dest.x > myX)      port = EAST;
    else if (dest.x < myX) port = WEST;
    else if (dest.y > myY) port = SOUTH;
    else if (dest.y < myY) port = NORTH;
  end

endmodule

// File: rtl/network_injector.sv
// Segments offered packets into HEADER/BODY/TAIL (or HT) flits for the router local input port,
// stalling on the packet's VC on_off bit and accepting the next packet during the last flit.
module network_injector
  import network_injector_pkg::*;
#(
  parameter int MY_X_ADDR = 0,
  parameter int MY_Y_ADDR = 0,
  parameter int MAX_FLITS = DEF_MAX_FLITS
) (
  input logic                clk,
  input logic                reset,
  network_injector_if.master bus
);

  localparam int LEN_W = $clog2(MAX_FLITS + 1);
  localparam int IDX_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;

  inj_state_t                          state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [VC_W-1:0]                     vc_q, vc_d;
  tile_address_t                       dest_q, dest_d;
  logic [LEN_W-1:0]                    len_q, len_d;
  logic [MAX_FLITS-1:0][PAYLOAD_W-1:0] data_q, data_d;
  logic                                wr_en_q, wr_en_d;
  flit_t                               flit_q, flit_d;

  port_t            routePort;
  flit_type_t       curType;
  logic [LEN_W-1:0] lenNorm;
  logic [IDX_W-1:0] lastIdx;
  logic             go, lastFlit, accept;

  injection_route_calc #(
    .MY_X_ADDR(MY_X_ADDR),
    .MY_Y_ADDR(MY_Y_ADDR)
  ) u_route (
    .dest(dest_q),
    .port(routePort)
  );

  // A zero length still carries one flit; oversize lengths are clamped.
  always_comb begin
    lenNorm = bus.pkt_len;
    if (bus.pkt_len == '0)                      lenNorm = LEN_W'(1);
    else if (bus.pkt_len > LEN_W'(MAX_FLITS))   lenNorm = LEN_W'(MAX_FLITS);
  end

  assign lastIdx       = IDX_W'(len_q - LEN_W'(1));
  assign go            = (state_q == SEND) && !bus.on_off_in[vc_q];
  assign lastFlit      = (idx_q == lastIdx);
  assign bus.pkt_ready = !reset && ((state_q == IDLE) || (go && lastFlit));
  assign accept        = bus.pkt_valid && bus.pkt_ready;

  always_comb begin
    if (len_q == LEN_W'(1))  curType = HT;
    else if (idx_q == '0)    curType = HEADER;
    else if (lastFlit)       curType = TAIL;
    else                     curType = BODY;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vc_d    = vc_q;
    dest_d  = dest_q;
    len_d   = len_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    flit_d  = flit_q;

    if (go) begin
      wr_en_d              = 1'b1;
      flit_d.flit_type     = curType;
      flit_d.next_hop_port = (curType == HEADER || curType == HT) ? routePort : LOCAL;
      flit_d.vc_id         = vc_q;
      flit_d.destination   = dest_q;
      flit_d.payload       = data_q[idx_q];
      idx_d                = idx_q + 1'b1;
      if (lastFlit) begin
        state_d = IDLE;
        idx_d   = '0;
      end
    end

    // Loading here also covers the zero-bubble reload while the tail goes out.
    if (accept) begin
      state_d = SEND;
      idx_d   = '0;
      vc_d    = bus.pkt_vc;
      dest_d  = bus.pkt_dest;
      len_d   = lenNorm;
      data_d  = bus.pkt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vc_q    <= '0;
      dest_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      flit_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vc_q    <= vc_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      flit_q  <= flit_d;
    end
  end

  assign bus.wr_en_out = wr_en_q;
  assign bus.flit_out  = flit_q;

endmodule

// File: tb/tb_network_injector.sv
// Directed bench for network_injector at tile (1,1): routing, segmentation, stalls, back-to-back and reset.
module tb_network_injector;
  import network_injector_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   testCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  network_injector_if #(.MAX_FLITS(4)) bus ();

  network_injector #(
    .MY_X_ADDR(1),
    .MY_Y_ADDR(1),
    .MAX_FLITS(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  function automatic flit_t mkFlit(input flit_type_t t, input port_t p, input logic [VC_W-1:0] vc,
                                   input logic [3:0] x, input logic [3:0] y, input logic [15:0] pl);
    flit_t f;
    f.flit_type     = t;
    f.next_hop_port = p;
    f.vc_id         = vc;
    f.destination.x = x;
    f.destination.y = y;
    f.payload       = pl;
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlit(input string tag, input flit_t expected);
    checkOutput({tag, ".wr"}, 32'(bus.wr_en_out), 32'd1);
    checkOutput({tag, ".flit"}, 32'(bus.flit_out), 32'(expected));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".wr"}, 32'(bus.wr_en_out), 32'd0);
  endtask

  task automatic checkReady(input string tag, input logic expected);
    #1;
    checkOutput({tag, ".ready"}, 32'(bus.pkt_ready), 32'(expected));
  endtask

  task automatic applyStimulus(input logic valid, input logic [VC_W-1:0] vc, input logic [3:0] x,
                               input logic [3:0] y, input logic [2:0] len, input logic [15:0] d0,
                               input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
    bus.pkt_valid  = valid;
    bus.pkt_vc     = vc;
    bus.pkt_dest.x = x;
    bus.pkt_dest.y = y;
    bus.pkt_len    = len;
    bus.pkt_data   = {d3, d2, d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.on_off_in = 2'b00;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    tick();
    checkOutput("rst.wr", 32'(bus.wr_en_out), 32'd0);
    checkOutput("rst.flit", 32'(bus.flit_out), 32'd0);
    checkReady("rst", 1'b0);
    reset = 1'b0;
    checkReady("rst.release", 1'b1);

    // Single HT flit east, two cycles after the handshake
    applyStimulus(1'b1, 1'b0, 4'd3, 4'd1, 3'd1, 16'h1111, 16'h0, 16'h0, 16'h0);
    checkReady("t1", 1'b1);
    tick();
    bus.pkt_valid = 1'b0;
    checkIdle("t1.lat");
    tick();
    checkFlit("t1.ht", mkFlit(HT, EAST, 1'b0, 4'd3, 4'd1, 16'h1111));
    tick();
    checkIdle("t1.after");

    // Four-flit packet north; inputs scrambled after the handshake
    applyStimulus(1'b1, 1'b1, 4'd1, 4'd0, 3'd4, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd7, 4'd7, 3'd1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
    checkIdle("t2.lat");
    tick();
    checkFlit("t2.head", mkFlit(HEADER, NORTH, 1'b1, 4'd1, 4'd0, 16'hA0A0));
    tick();
    checkFlit("t2.body1", mkFlit(BODY, LOCAL, 1'b1, 4'd1, 4'd0, 16'hB0B0));
    checkReady("t2.mid", 1'b0);
    tick();
    checkFlit("t2.body2", mkFlit(BODY, LOCAL, 1'b1, 4'd1, 4'd0, 16'hC0C0));
    checkReady("t2.last", 1'b1);
    tick();
    checkFlit("t2.tail", mkFlit(TAIL, LOCAL, 1'b1, 4'd1, 4'd0, 16'hD0D0));
    tick();
    checkIdle("t2.after");

    // Back-pressure on vc1 for three cycles while vc0's bit toggles
    applyStimulus(1'b1, 1'b1, 4'd0, 4'd1, 3'd3, 16'h3001, 16'h3002, 16'h3003, 16'h0);
    tick();
    bus.pkt_valid = 1'b0;
    checkIdle("t3.lat");
    tick();
    checkFlit("t3.head", mkFlit(HEADER, WEST, 1'b1, 4'd0, 4'd1, 16'h3001));
    bus.on_off_in = 2'b10;
    tick();
    checkIdle("t3.stall1");
    checkOutput("t3.hold", 32'(bus.flit_out), 32'(mkFlit(HEADER, WEST, 1'b1, 4'd0, 4'd1, 16'h3001)));
    bus.on_off_in = 2'b11;
    checkReady("t3.stall", 1'b0);
    tick();
    checkIdle("t3.stall2");
    bus.on_off_in = 2'b10;
    tick();
    checkIdle("t3.stall3");
    bus.on_off_in = 2'b00;
    tick();
    checkFlit("t3.body", mkFlit(BODY, LOCAL, 1'b1, 4'd0, 4'd1, 16'h3002));
    tick();
    checkFlit("t3.tail", mkFlit(TAIL, LOCAL, 1'b1, 4'd0, 4'd1, 16'h3003));
    tick();
    checkIdle("t3.after");

    // Back-to-back two-flit packets with valid held high
    applyStimulus(1'b1, 1'b0, 4'd1, 4'd3, 3'd2, 16'h4001, 16'h4002, 16'h0, 16'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 4'd2, 4'd2, 3'd2, 16'h5001, 16'h5002, 16'h0, 16'h0);
    checkIdle("t4.lat");
    checkReady("t4.first", 1'b0);
    tick();
    checkFlit("t4.p1head", mkFlit(HEADER, SOUTH, 1'b0, 4'd1, 4'd3, 16'h4001));
    checkReady("t4.reload", 1'b1);
    tick();
    checkFlit("t4.p1tail", mkFlit(TAIL, LOCAL, 1'b0, 4'd1, 4'd3, 16'h4002));
    bus.pkt_valid = 1'b0;
    tick();
    checkFlit("t4.p2head", mkFlit(HEADER, EAST, 1'b1, 4'd2, 4'd2, 16'h5001));
    tick();
    checkFlit("t4.p2tail", mkFlit(TAIL, LOCAL, 1'b1, 4'd2, 4'd2, 16'h5002));
    tick();
    checkIdle("t4.after");

    // Local destination
    applyStimulus(1'b1, 1'b0, 4'd1, 4'd1, 3'd1, 16'h6001, 16'h0, 16'h0, 16'h0);
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    checkFlit("t5.local", mkFlit(HT, LOCAL, 1'b0, 4'd1, 4'd1, 16'h6001));
    tick();
    checkIdle("t5.after");

    // Zero length becomes a single HT flit with data[0]
    applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 3'd0, 16'h9001, 16'h9999, 16'h0, 16'h0);
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    checkFlit("t6.len0", mkFlit(HT, WEST, 1'b1, 4'd0, 4'd0, 16'h9001));
    tick();
    checkIdle("t6.after");

    // Oversize length clamps to four flits
    applyStimulus(1'b1, 1'b0, 4'd2, 4'd0, 3'd7, 16'hA001, 16'hA002, 16'hA003, 16'hA004);
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    checkFlit("t7.head", mkFlit(HEADER, EAST, 1'b0, 4'd2, 4'd0, 16'hA001));
    tick();
    tick();
    tick();
    checkFlit("t7.tail", mkFlit(TAIL, LOCAL, 1'b0, 4'd2, 4'd0, 16'hA004));
    tick();
    checkIdle("t7.after");

    // Reset after the first flit drops the rest of the packet
    applyStimulus(1'b1, 1'b0, 4'd2, 4'd1, 3'd4, 16'h7001, 16'h7002, 16'h7003, 16'h7004);
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    checkFlit("t8.head", mkFlit(HEADER, EAST, 1'b0, 4'd2, 4'd1, 16'h7001));
    reset = 1'b1;
    tick();
    checkIdle("t8.reset");
    checkReady("t8.inreset", 1'b0);
    reset = 1'b0;
    checkReady("t8.release", 1'b1);
    applyStimulus(1'b1, 1'b1, 4'd1, 4'd2, 3'd2, 16'h8001, 16'h8002, 16'h0, 16'h0);
    tick();
    bus.pkt_valid = 1'b0;
    checkIdle("t8.lat");
    tick();
    checkFlit("t8.nhead", mkFlit(HEADER, SOUTH, 1'b1, 4'd1, 4'd2, 16'h8001));
    tick();
    checkFlit("t8.ntail", mkFlit(TAIL, LOCAL, 1'b1, 4'd1, 4'd2, 16'h8002));
    tick();
    checkIdle("t8.after");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/network_injector.md
# network_injector

Packet-to-flit injection engine for a tile's local port. It accepts one packet per valid/ready handshake and segments it into HEADER/BODY/TAIL flits, or a single HT flit. It stamps each header with the look-ahead XY-DOR output port and drives the router's local-port `wr_en_in`/`flit_in` pair. It obeys the router's per-VC `on_off` back-pressure, making it the transmitting end of the local input port.

## Interface
- `MY_X_ADDR`, default 0: X coordinate of this tile.
- `MY_Y_ADDR`, default 0: Y coordinate of this tile.
- `MAX_FLITS`, default 4: maximum flits per packet; must be ≥1.
- `clk` input, 1: clock; the only clock.
- `reset` input, 1: synchronous, active-high reset.
- `pkt_valid` input, 1: packet offered.
- `pkt_ready` output, 1: packet accepted when `pkt_valid && pkt_ready`.
- `pkt_vc` input, `$clog2(VC_PER_PORT)`: virtual channel for the whole packet.
- `pkt_dest` input, `tile_address_t`: destination x/y.
- `pkt_len` input, `$clog2(MAX_FLITS+1)`: flit count 1..MAX_FLITS.
- `pkt_data` input, `[MAX_FLITS][payload width]`: flit payloads; index 0 is sent first.
- `on_off_in` input, `VC_PER_PORT`: bit v=1 means VC v is stopped.
- `wr_en_out` output, 1: `flit_out` valid this cycle.
- `flit_out` output, `flit_t`: flit to the router local input port.

## Operation
- FSM has two states:
  - **IDLE**: `pkt_ready`=1. On handshake, capture vc, dest, len and data; set idx=0; go to SEND.
  - **SEND**: the packet is being transmitted flit by flit.
- Per SEND cycle, go = `!on_off_in[vc_q]`.
  - If go: register flit idx into `flit_out`, assert `wr_en_out` on the next cycle, idx++.
  - If !go: idx holds and `wr_en_out` is 0 on the next cycle.
- Flit type:
  - len==1 → HT.
  - idx==0 → HEADER.
  - idx==len-1 → TAIL.
  - otherwise → BODY.
- Every flit of a packet carries `vc_id`=vc_q and `destination`=dest_q.
- `next_hop_port` is meaningful on HEADER/HT flits and is zero on BODY/TAIL.
- Route computation (XY-DOR), X resolved first:
  - dest.x>MY_X → EAST.
  - dest.x<MY_X → WEST.
  - Otherwise, dest.y>MY_Y → SOUTH.
  - Otherwise, dest.y<MY_Y → NORTH.
  - Otherwise → LOCAL.
- Back-to-back packets: `pkt_ready` is also 1 in SEND when go && idx==len_q-1.
  - A handshake in that cycle reloads the registers and stays in SEND with idx=0, giving zero bubbles.
  - Otherwise the FSM returns to IDLE after the last flit.
- `pkt_len`==0 is treated as 1 (a single HT flit carrying `pkt_data[0]`).
- `pkt_len`>MAX_FLITS is clamped to MAX_FLITS.
- `pkt_*` inputs are sampled only at the handshake; the offering side may change them afterwards without effect.
- `on_off_in` toggling mid-packet only stalls; flit order and content are unchanged. Flits of one packet are never interleaved with flits of another.

## Timing
- Reset values:
  - state=IDLE, idx=0, `wr_en_out`=0, `flit_out`='0.
  - `pkt_ready`=0 while `reset` is high, then 1 from the first cycle after release.
- Latency: a handshake at edge E0 gives the first `wr_en_out`=1 in the cycle after E1, provided `on_off_in[vc]`=0 during the cycle after E0. Latency is 2 cycles minimum.
- Throughput: 1 flit/cycle while on_off is clear; a packet of L flits occupies L SEND cycles.
- `wr_en_out` and `flit_out` are registered, with no combinational path from `on_off_in`.
- `pkt_ready` depends combinationally on state, idx and `on_off_in`.
- When `wr_en_out`=0, `flit_out` holds its last value and is don't-care for the router.
- Reset asserted mid-packet: the remaining flits are dropped and `wr_en_out`=0 on the cycle after the reset edge. No partial-packet recovery is done; the router side must be reset together with this block.
- `on_off_in` is used as sampled in the deciding cycle. The router's on_off threshold already covers the one flit in flight.

## Structure
- `tile_address_t`, `flit_t`, the flit-type enum (HEADER/BODY/TAIL/HT), `port_t`, `VC_PER_PORT` and the payload width come from the network defines package. No new package is needed.
- Add `MAX_FLITS` to the user defines if it is shared with the ejection side.
- Sub-module `injection_route_calc`: combinational, parameters MY_X_ADDR/MY_Y_ADDR, input `tile_address_t` dest, output `port_t` port. It is instantiated once, on dest_q.
- The top holds the FSM, the idx counter, the packet registers and the output flit register.

## Test plan
- **Single flit:** MY=(1,1), dest (3,1), len=1, vc=0, on_off=0 → one HT flit, `next_hop_port`=EAST, `wr_en_out` exactly 2 cycles after the handshake.
- **Four-flit packet:** dest (1,0), len=4, data A,B,C,D → HEADER(NORTH),A / BODY,B / BODY,C / TAIL,D on 4 consecutive cycles, all with `vc_id`=the packet's vc.
- **Back-pressure:** len=3 on vc=1, `on_off_in[1]`=1 for 3 cycles after the header and `on_off_in[0]` toggling meanwhile → `wr_en_out`=0 for exactly those 3 cycles, then BODY, TAIL; stalls track vc 1 only.
- **Back-to-back:** two len=2 packets with `pkt_valid` held high → 4 consecutive `wr_en_out` cycles with no gap; the second header has the correct route.
- **Local and reset:** dest==(MY_X,MY_Y) → `next_hop_port`=LOCAL. Reset asserted after flit 1 of a len=4 packet → `wr_en_out`=0 next cycle, `pkt_ready`=1 after release, next packet sent cleanly.
